vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_sync_gen_if.sv | 21 ++
 rtl/vga_pix_tick.sv | 26 ++
 rtl/vga_sync_gen.sv | 132 +++++++++++++
 tb/tb_vga_sync_gen.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and small timing helpers
// used by the sync generator and its sub-blocks.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Inclusive range test used for both sync windows.
    function automatic logic in_span(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// DAC-side bus of the VGA sync generator: colour, syncs, blank and pixel clock.
interface vga_sync_gen_if;
    logic [9:0] vga_r;
    logic [9:0] vga_g;
    logic [9:0] vga_b;
    logic       vga_hs_n;
    logic       vga_vs_n;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       vga_clk;

    modport master (
        output vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n,
        output vga_blank_n, vga_sync_n, vga_clk
    );

    modport slave (
        input vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n,
        input vga_blank_n, vga_sync_n, vga_clk
    );
endinterface

// File: rtl/vga_pix_tick.sv
// Divide-by-two pixel strobe: the phase register toggles every clk and its
// high phase is the pixel tick.
module vga_pix_tick (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);
    logic phase_q;
    logic phase_d;

    // Next phase is always the opposite phase.
    always_comb begin
        phase_d = ~phase_q;
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign pix_tick = phase_q;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, frame strobe, and a one-pixel
// registered output stage feeding the DAC bus.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic           clk,
    input  logic           reset,
    output logic [9:0]     x,
    output logic [9:0]     y,
    output logic           video_on,
    output logic           pix_tick,
    output logic           frame_tick,
    input  logic [9:0]     red_in,
    input  logic [9:0]     green_in,
    input  logic [9:0]     blue_in,
    vga_sync_gen_if.master vga
);
    localparam cnt_t H_LAST   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam cnt_t FT_LINE  = cnt_t'(V_VISIBLE + 1);

    cnt_t       h_cnt_q, h_cnt_d;
    cnt_t       v_cnt_q, v_cnt_d;
    logic [9:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       hs_n_q, hs_n_d;
    logic       vs_n_q, vs_n_d;
    logic       blank_n_q, blank_n_d;
    logic       raw_hs;
    logic       raw_vs;

    vga_pix_tick u_pix_tick (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pix_tick)
    );

    assign x          = h_cnt_q;
    assign y          = v_cnt_q;
    assign video_on   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign frame_tick = pix_tick && (h_cnt_q == 10'd0) && (v_cnt_q == FT_LINE);
    assign raw_hs     = in_span(h_cnt_q, HS_START, HS_END);
    assign raw_vs     = in_span(v_cnt_q, VS_START, VS_END);

    // Raster counters: the line counter steps only when the pixel counter wraps.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
                v_cnt_d = v_cnt_q;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Output stage: one pixel behind x/y, colour forced to black outside the active area.
    always_comb begin
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_n_d    = hs_n_q;
        vs_n_d    = vs_n_q;
        blank_n_d = blank_n_q;
        if (pix_tick) begin
            r_d       = video_on ? red_in   : 10'd0;
            g_d       = video_on ? green_in : 10'd0;
            b_d       = video_on ? blue_in  : 10'd0;
            hs_n_d    = ~raw_hs;
            vs_n_d    = ~raw_vs;
            blank_n_d = video_on;
        end else begin
            blank_n_d = blank_n_q;
        end
    end

    // State registers for counters and DAC outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            r_q       <= 10'd0;
            g_q       <= 10'd0;
            b_q       <= 10'd0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_n_q    <= hs_n_d;
            vs_n_q    <= vs_n_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign vga.vga_r       = r_q;
    assign vga.vga_g       = g_q;
    assign vga.vga_b       = b_q;
    assign vga.vga_hs_n    = hs_n_q;
    assign vga.vga_vs_n    = vs_n_q;
    assign vga.vga_blank_n = blank_n_q;
    assign vga.vga_sync_n  = 1'b0;
    assign vga.vga_clk     = ~pix_tick;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen using a shrunken raster; expected values
// come from a pixel-count reference model of the raster timing.
module tb_vga_sync_gen;
    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] red_in = 10'd0, green_in = 10'd0, blue_in = 10'd0;
    logic [9:0] x, y;
    logic       video_on, pix_tick, frame_tick;

    vga_sync_gen_if vga_bus ();

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .pix_tick   (pix_tick),
        .frame_tick (frame_tick),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .vga        (vga_bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    // Reference model: pixel index since reset plus the last captured pixel.
    int m_phase = 0, m_p = 0, m_pv = 0;
    int m_px = 0, m_py = 0, m_pr = 0, m_pg = 0, m_pb = 0;
    int cyc = 0, last_ft = -1, hs_low = 0, ft_seen = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int mx();
        return m_p % HT;
    endfunction

    function automatic int my();
        return (m_p / HT) % VT;
    endfunction

    function automatic int vis(input int xx, input int yy);
        return ((xx < HV) && (yy < VV)) ? 1 : 0;
    endfunction

    task automatic compare_all();
        int ex, ey, pv, exp_hs, exp_vs;
        ex = mx();
        ey = my();
        pv = (m_pv != 0) ? vis(m_px, m_py) : 0;
        exp_hs = (m_pv != 0) ? (((m_px >= HV + HF) && (m_px < HV + HF + HS)) ? 0 : 1) : 1;
        exp_vs = (m_pv != 0) ? (((m_py >= VV + VF) && (m_py < VV + VF + VS)) ? 0 : 1) : 1;
        check_eq("x", int'(x), ex);
        check_eq("y", int'(y), ey);
        check_eq("pix_tick", int'(pix_tick), m_phase);
        check_eq("video_on", int'(video_on), vis(ex, ey));
        check_eq("frame_tick", int'(frame_tick), (m_phase == 1 && ex == 0 && ey == VV + 1) ? 1 : 0);
        check_eq("hs_n", int'(vga_bus.vga_hs_n), exp_hs);
        check_eq("vs_n", int'(vga_bus.vga_vs_n), exp_vs);
        check_eq("blank_n", int'(vga_bus.vga_blank_n), pv);
        check_eq("sync_n", int'(vga_bus.vga_sync_n), 0);
        check_eq("vga_clk", int'(vga_bus.vga_clk), (m_phase == 0) ? 1 : 0);
        check_eq("vga_r", int'(vga_bus.vga_r), (pv != 0) ? m_pr : 0);
        check_eq("vga_g", int'(vga_bus.vga_g), (pv != 0) ? m_pg : 0);
        check_eq("vga_b", int'(vga_bus.vga_b), (pv != 0) ? m_pb : 0);
        if (frame_tick) begin
            ft_seen++;
            if (last_ft >= 0) check_eq("frame_period", cyc - last_ft, 2 * HT * VT);
            last_ft = cyc;
        end
        if (!vga_bus.vga_hs_n) begin
            hs_low++;
        end else begin
            if (hs_low != 0) check_eq("hs_width", hs_low, 2 * HS);
            hs_low = 0;
        end
    endtask

    // mode 0: random colour, 1: red follows x, 2: red stuck at full scale
    task automatic step(input bit rst, input int mode);
        reset    = rst;
        red_in   = 10'($urandom);
        green_in = 10'($urandom);
        blue_in  = 10'($urandom);
        if (mode == 1) red_in = 10'(mx());
        else if (mode == 2) red_in = 10'h3ff;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_phase = 0; m_p = 0; m_pv = 0; last_ft = -1; hs_low = 0;
        end else begin
            if (m_phase == 1) begin
                m_pv = 1; m_px = mx(); m_py = my();
                m_pr = int'(red_in); m_pg = int'(green_in); m_pb = int'(blue_in);
                m_p++;
            end
            m_phase = 1 - m_phase;
        end
        #1;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int guard;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 0);
        for (int i = 0; i < 2 * 2 * HT * VT + 7; i++) step(1'b0, 0);
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1);
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 2);
        // Run to a point inside hsync in the middle of the frame, then pulse reset.
        guard = 0;
        while (!(mx() == HV + HF + 1 && my() == 6) && guard < 4 * HT * VT) begin
            step(1'b0, 0);
            guard++;
        end
        check_eq("pre_reset_x", int'(x), HV + HF + 1);
        check_eq("pre_reset_y", int'(y), 6);
        step(1'b1, 0);
        check_eq("mid_reset_x", int'(x), 0);
        check_eq("mid_reset_y", int'(y), 0);
        check_eq("mid_reset_hs_n", int'(vga_bus.vga_hs_n), 1);
        for (int i = 0; i < 3 * HT * VT; i++) step(1'b0, 0);
        check_eq("frames_seen", (ft_seen >= 5) ? 1 : 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
